nv_nvdla_cdp_rdma_rd_arb: RTL and testbench
===========================================

# nv_nvdla_cdp_rdma_rd_arb

Credit-checked, round-robin arbiter that shares one DMA read-request port between two CDP RDMA requesters (e.g. the main ingress and a prefetch/refill path). Each requester owns a private latency-FIFO credit pool, so a request is granted only when its response beats are guaranteed space downstream. The winning request is registered onto the single outbound `mcif` read-request channel, tagged with its source for context-queue routing. The block also exports a read-stall performance counter.

## Interface
- `PD_W`, 79: request payload width, `{size[14:0], addr[63:0]}`.
- `SIZE_LSB`, 64: LSB of the size field. The request occupies `size+1` 32-byte atoms, one response beat each.
- `CDT_DEPTH`, 80: latency-FIFO entries per requester; also the credit reset value.
- `CDT_W`, 8: credit counter width. Must satisfy `CDT_DEPTH < 2^CDT_W`.

Ports:
- `nvdla_core_clk` in 1: the single clock.
- `nvdla_core_rst` in 1: asynchronous, active-high reset.
- `arb_en` in 1: when 0, no new grants are issued; the output register still drains.
- `req0_valid` in 1 / `req0_ready` out 1 / `req0_pd` in PD_W: requester 0.
- `req1_valid` in 1 / `req1_ready` out 1 / `req1_pd` in PD_W: requester 1.
- `cdt0_pop` in 1 / `cdt1_pop` in 1: one credit returned per asserted cycle (latency-FIFO pop).
- `out_valid` out 1 / `out_ready` in 1 / `out_pd` out PD_W: outbound read request.
- `out_src` out 1: source of the request on `out_pd` (0 = req0, 1 = req1).
- `stall_clr` in 1: synchronous clear of `perf_stall`.
- `perf_stall` out 32: stall-cycle counter.
- `err_cdt_ovf` out 1: sticky flag, credit overflow.
- `err_oversize` out 1: sticky flag, request larger than the pool.

## Operation
- Per-requester demand: `need_i = pd_i[SIZE_LSB+14:SIZE_LSB] + 1`, computed at 16 bits.
- Eligibility: `elig_i = arb_en & req_i_valid & (need_i <= cdt_i)`.
- Output slot is free when `!out_valid | out_ready`.
- Round-robin on the `last_gnt` register:
  - If both requesters are eligible, grant the one that is not `last_gnt`.
  - If only one is eligible, grant it.
  - Reset value of `last_gnt` is 1, so req0 wins the first contention.
  - `last_gnt` updates only on a grant.
- `req_i_ready = grant_i`, combinational from registered state plus the current-cycle valids and `out_ready`. At most one grant per cycle.
- On a grant:
  - `out_pd <= req_i_pd`, `out_src <= i`, `out_valid <= 1`.
  - Without a grant, `out_valid` clears when `out_ready` is high.
- Credit update: `cdt_i <= cdt_i - (grant_i ? need_i : 0) + cdt_i_pop`.
  - A same-cycle grant and pop are both applied.
  - If the result would exceed `CDT_DEPTH`, clamp to `CDT_DEPTH` and set `err_cdt_ovf`.
- Oversize request (`need_i > CDT_DEPTH` while `req_i_valid`):
  - Set `err_oversize`.
  - The request is never granted.
  - The other requester continues to be served normally.
- `perf_stall`:
  - Increments in any cycle where `(req0_valid | req1_valid) & arb_en` and no grant occurs.
  - Saturates at `0xFFFF_FFFF`.
  - `stall_clr` zeroes it and takes priority over increment.
- Sticky error flags clear only on reset.
- Payload stability: a requester holds `pd` stable while valid and not ready. The arbiter does not sample `pd` except in the grant cycle.

## Timing
Reset values:
- `out_valid` = 0, `out_pd` = 0, `out_src` = 0.
- `perf_stall` = 0, error flags = 0.
- `cdt0` = `cdt1` = `CDT_DEPTH`, `last_gnt` = 1.
- `req_i_ready` = 0, since it is a function of the registered state.

Latency and throughput:
- Request-to-output latency: 1 cycle (grant in cycle N, `out_valid` in N+1).
- Full throughput: back-to-back grants every cycle while `out_ready` stays high and credits suffice.
- Credits consumed in cycle N are visible to the eligibility check in N+1. A pop in N can enable a grant in N+1, not in N.

Handshake and reset:
- `out_valid` and `out_pd` hold unchanged while `out_valid & !out_ready`.
- Reset asserted mid-transfer drops any pending output request immediately. Credits restore to `CDT_DEPTH`; outstanding responses are the system's responsibility.
- Deasserting `arb_en` blocks grants from the same cycle. A request already registered in the output still completes.

## Test plan
- **Single request:** req0 `size=3`, `out_ready=1` -> `req0_ready` in cycle 0, `out_valid`/`out_src=0` in cycle 1, `cdt0` 80 -> 76; req1 pool untouched.
- **Contention:** both valid continuously with `size=0`, ample credits -> grants alternate req0, req1, req0, ...; `perf_stall` stays 0.
- **Credit exhaustion:**
  - req0 issues ten `size=7` requests with no pops -> `cdt0=0`.
  - The 11th request stalls and `perf_stall` counts each cycle.
  - 8 `cdt0_pop` pulses -> grant in the cycle after the 8th pop.
- **Backpressure:** `out_ready=0` for 5 cycles with a request registered -> `out_pd` stable, no further grants, `perf_stall`+=5 while a requester is valid; release -> the next grant is in the same cycle as `out_ready` rises.
- **Simultaneous grant+pop:** `cdt1=10`, grant `size=1` plus `cdt1_pop` in the same cycle -> `cdt1=9`.
- **Error flags:**
  - Pop with `cdt0=80` -> stays 80 and `err_cdt_ovf=1`.
  - req1 with `size=100` -> `err_oversize=1`, never granted, while req0 traffic proceeds.

Source files
------------

// File: rtl/nv_nvdla_cdp_rdma_rd_arb_if.sv
// Read-request handshake channel: valid/ready plus {size, addr} payload.
// Used both for the requester inputs and the single outbound mcif request.
interface nv_nvdla_cdp_rdma_rd_arb_if #(
  parameter int PD_W = 79
);
  logic            valid;
  logic            ready;
  logic [PD_W-1:0] pd;

  modport master (output valid, output pd, input ready);
  modport slave  (input valid, input pd, output ready);
endinterface

// File: rtl/nv_nvdla_cdp_rdma_rd_arb.sv
// Credit-checked round-robin arbiter sharing one read-request port between two requesters.
// Grant in cycle N shows on out in N+1; out holds while !out.ready and no grant issues until the slot frees.
module nv_nvdla_cdp_rdma_rd_arb #(
  parameter int PD_W      = 79,
  parameter int SIZE_LSB  = 64,
  parameter int CDT_DEPTH = 80,
  parameter int CDT_W     = 8
) (
  input  logic                             nvdla_core_clk,
  input  logic                             nvdla_core_rst,
  input  logic                             arb_en,
  nv_nvdla_cdp_rdma_rd_arb_if.slave        req0,
  nv_nvdla_cdp_rdma_rd_arb_if.slave        req1,
  input  logic                             cdt0_pop,
  input  logic                             cdt1_pop,
  nv_nvdla_cdp_rdma_rd_arb_if.master       out,
  output logic                             out_src,
  input  logic                             stall_clr,
  output logic [31:0]                      perf_stall,
  output logic                             err_cdt_ovf,
  output logic                             err_oversize
);

  localparam logic [15:0]      DEPTH16 = 16'(CDT_DEPTH);
  localparam logic [CDT_W-1:0] DEPTH_C = CDT_W'(CDT_DEPTH);

  logic [CDT_W-1:0] cdt0_q, cdt0_d, cdt1_q, cdt1_d;
  logic             last_gnt_q, last_gnt_d;
  logic             out_valid_q, out_valid_d;
  logic [PD_W-1:0]  out_pd_q, out_pd_d;
  logic             out_src_q, out_src_d;
  logic [31:0]      perf_stall_q, perf_stall_d;
  logic             err_cdt_ovf_q, err_cdt_ovf_d;
  logic             err_oversize_q, err_oversize_d;

  logic [15:0]      need0, need1;
  logic             slot_free, elig0, elig1, gnt0, gnt1, any_req;
  logic [CDT_W:0]   upd0, upd1;

  // Returns {overflow, next credit}; a grant only happens when need <= cdt, so no underflow.
  function automatic logic [CDT_W:0] cdt_upd(input logic [CDT_W-1:0] cdt, input logic gnt,
                                             input logic [15:0] need, input logic pop);
    logic [15:0] sum;
    sum = 16'(cdt) - (gnt ? need : 16'd0) + {15'd0, pop};
    if (sum > DEPTH16) cdt_upd = {1'b1, DEPTH_C};
    else               cdt_upd = {1'b0, sum[CDT_W-1:0]};
  endfunction

  assign need0 = {1'b0, req0.pd[SIZE_LSB+14:SIZE_LSB]} + 16'd1;
  assign need1 = {1'b0, req1.pd[SIZE_LSB+14:SIZE_LSB]} + 16'd1;

  assign slot_free = !out_valid_q | out.ready;
  assign elig0     = arb_en & req0.valid & (need0 <= 16'(cdt0_q)) & slot_free;
  assign elig1     = arb_en & req1.valid & (need1 <= 16'(cdt1_q)) & slot_free;
  // last_gnt_q == 1 means req1 won last, so req0 takes the next contention.
  assign gnt0      = elig0 & (!elig1 | last_gnt_q);
  assign gnt1      = elig1 & (!elig0 | !last_gnt_q);
  assign any_req   = (req0.valid | req1.valid) & arb_en;

  assign upd0 = cdt_upd(cdt0_q, gnt0, need0, cdt0_pop);
  assign upd1 = cdt_upd(cdt1_q, gnt1, need1, cdt1_pop);

  always_comb begin
    out_valid_d    = out_valid_q;
    out_pd_d       = out_pd_q;
    out_src_d      = out_src_q;
    last_gnt_d     = last_gnt_q;
    perf_stall_d   = perf_stall_q;
    cdt0_d         = upd0[CDT_W-1:0];
    cdt1_d         = upd1[CDT_W-1:0];
    err_cdt_ovf_d  = err_cdt_ovf_q | upd0[CDT_W] | upd1[CDT_W];
    err_oversize_d = err_oversize_q
                   | (req0.valid & (need0 > DEPTH16))
                   | (req1.valid & (need1 > DEPTH16));

    if (gnt0) begin
      out_valid_d = 1'b1;
      out_pd_d    = req0.pd;
      out_src_d   = 1'b0;
      last_gnt_d  = 1'b0;
    end else if (gnt1) begin
      out_valid_d = 1'b1;
      out_pd_d    = req1.pd;
      out_src_d   = 1'b1;
      last_gnt_d  = 1'b1;
    end else if (out.ready) begin
      out_valid_d = 1'b0;
    end

    if (stall_clr) begin
      perf_stall_d = 32'd0;
    end else if (any_req && !(gnt0 || gnt1) && (perf_stall_q != 32'hFFFF_FFFF)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      cdt0_q         <= DEPTH_C;
      cdt1_q         <= DEPTH_C;
      last_gnt_q     <= 1'b1;
      out_valid_q    <= 1'b0;
      out_pd_q       <= '0;
      out_src_q      <= 1'b0;
      perf_stall_q   <= 32'd0;
      err_cdt_ovf_q  <= 1'b0;
      err_oversize_q <= 1'b0;
    end else begin
      cdt0_q         <= cdt0_d;
      cdt1_q         <= cdt1_d;
      last_gnt_q     <= last_gnt_d;
      out_valid_q    <= out_valid_d;
      out_pd_q       <= out_pd_d;
      out_src_q      <= out_src_d;
      perf_stall_q   <= perf_stall_d;
      err_cdt_ovf_q  <= err_cdt_ovf_d;
      err_oversize_q <= err_oversize_d;
    end
  end

  assign req0.ready   = gnt0;
  assign req1.ready   = gnt1;
  assign out.valid    = out_valid_q;
  assign out.pd       = out_pd_q;
  assign out_src      = out_src_q;
  assign perf_stall   = perf_stall_q;
  assign err_cdt_ovf  = err_cdt_ovf_q;
  assign err_oversize = err_oversize_q;

endmodule

// File: tb/tb_nv_nvdla_cdp_rdma_rd_arb.sv
// Bench for the CDP RDMA read arbiter: vector table for grant decisions, hand sequences
// for credit/backpressure corners, and a scoreboard on the outbound request stream.
module tb_nv_nvdla_cdp_rdma_rd_arb;
  localparam int PD_W = 79;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        arb_en, cdt0_pop, cdt1_pop, stall_clr;
  logic        out_src, err_cdt_ovf, err_oversize;
  logic [31:0] perf_stall;

  nv_nvdla_cdp_rdma_rd_arb_if #(.PD_W(PD_W)) req0_if ();
  nv_nvdla_cdp_rdma_rd_arb_if #(.PD_W(PD_W)) req1_if ();
  nv_nvdla_cdp_rdma_rd_arb_if #(.PD_W(PD_W)) out_if ();

  nv_nvdla_cdp_rdma_rd_arb dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .arb_en         (arb_en),
    .req0           (req0_if),
    .req1           (req1_if),
    .cdt0_pop       (cdt0_pop),
    .cdt1_pop       (cdt1_pop),
    .out            (out_if),
    .out_src        (out_src),
    .stall_clr      (stall_clr),
    .perf_stall     (perf_stall),
    .err_cdt_ovf    (err_cdt_ovf),
    .err_oversize   (err_oversize)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic            src;
    logic [PD_W-1:0] pd;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  typedef struct {
    logic        en;
    logic        v0;
    logic [14:0] s0;
    logic        v1;
    logic [14:0] s1;
    logic        ordy;
    logic        r0;
    logic        r1;
  } vec_t;
  vec_t vt[12];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_pd(input string name, input logic [PD_W-1:0] act, input logic [PD_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [PD_W-1:0] mk_pd(input logic [14:0] sz, input logic [63:0] a);
    return {sz, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    arb_en       = 1'b1;
    req0_if.valid = 1'b0;
    req1_if.valid = 1'b0;
    req0_if.pd    = '0;
    req1_if.pd    = '0;
    cdt0_pop     = 1'b0;
    cdt1_pop     = 1'b0;
    stall_clr    = 1'b0;
    out_if.ready = 1'b1;
  endtask

  // Asserting reset must drop a pending outbound request at once, without a clock edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk1("rst_out_valid_async", out_if.valid, 1'b0);
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Scoreboard: a grant seen in cycle N is expected on the next accepted outbound beat.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (out_if.valid && out_if.ready) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected: got beat %h expected none", out_if.pd);
        end else begin
          e = sb.pop_front();
          chk_pd("sb_out_pd", out_if.pd, e.pd);
          chk1("sb_out_src", out_src, e.src);
        end
      end
      if (req0_if.ready && req1_if.ready) begin
        n_tests++;
        n_fail++;
        $display("FAIL one_hot_grant: got both ready expected at most one");
      end
      if (req0_if.valid && req0_if.ready) sb.push_back({1'b0, req0_if.pd});
      if (req1_if.valid && req1_if.ready) sb.push_back({1'b1, req1_if.pd});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // en v0 s0 v1 s1 ordy | r0 r1 ; applied back-to-back, round-robin and credit state carries over
    vt[0]  = '{1'b1, 1'b1, 15'd3,  1'b0, 15'd0,   1'b1, 1'b1, 1'b0};
    vt[1]  = '{1'b1, 1'b1, 15'd0,  1'b1, 15'd0,   1'b1, 1'b0, 1'b1};
    vt[2]  = '{1'b1, 1'b1, 15'd0,  1'b1, 15'd0,   1'b1, 1'b1, 1'b0};
    vt[3]  = '{1'b0, 1'b1, 15'd0,  1'b1, 15'd0,   1'b1, 1'b0, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 15'd0,  1'b1, 15'd5,   1'b1, 1'b0, 1'b1};
    vt[5]  = '{1'b1, 1'b1, 15'd0,  1'b1, 15'd100, 1'b1, 1'b1, 1'b0};
    vt[6]  = '{1'b1, 1'b0, 15'd0,  1'b1, 15'd79,  1'b1, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 1'b1, 15'd79, 1'b0, 15'd0,   1'b1, 1'b0, 1'b0};
    vt[8]  = '{1'b1, 1'b1, 15'd0,  1'b0, 15'd0,   1'b0, 1'b1, 1'b0};
    vt[9]  = '{1'b1, 1'b1, 15'd0,  1'b1, 15'd0,   1'b0, 1'b0, 1'b0};
    vt[10] = '{1'b1, 1'b1, 15'd0,  1'b1, 15'd0,   1'b1, 1'b0, 1'b1};
    vt[11] = '{1'b1, 1'b1, 15'd1,  1'b1, 15'd1,   1'b1, 1'b1, 1'b0};

    idle_inputs();
    #2;
    do_reset();

    // Reset state
    @(negedge clk);
    chk1("rst_out_valid", out_if.valid, 1'b0);
    chk_pd("rst_out_pd", out_if.pd, '0);
    chk1("rst_out_src", out_src, 1'b0);
    chkn("rst_perf_stall", int'(perf_stall), 0);
    chk1("rst_err_cdt_ovf", err_cdt_ovf, 1'b0);
    chk1("rst_err_oversize", err_oversize, 1'b0);
    chk1("rst_req0_ready", req0_if.ready, 1'b0);
    chkn("rst_cdt0", int'(dut.cdt0_q), 80);
    chkn("rst_cdt1", int'(dut.cdt1_q), 80);
    tick();

    // Single request
    req0_if.valid = 1'b1;
    req0_if.pd    = mk_pd(15'd3, 64'hA000);
    @(negedge clk);
    chk1("single_req0_ready", req0_if.ready, 1'b1);
    tick();
    req0_if.valid = 1'b0;
    @(negedge clk);
    chk1("single_out_valid", out_if.valid, 1'b1);
    chk1("single_out_src", out_src, 1'b0);
    chkn("single_cdt0", int'(dut.cdt0_q), 76);
    chkn("single_cdt1", int'(dut.cdt1_q), 80);
    tick();

    // Vector table
    do_reset();
    for (int k = 0; k < 12; k++) begin
      arb_en        = vt[k].en;
      req0_if.valid = vt[k].v0;
      req1_if.valid = vt[k].v1;
      req0_if.pd    = mk_pd(vt[k].s0, 64'h1000 + 64'(k) * 64'd16);
      req1_if.pd    = mk_pd(vt[k].s1, 64'h2000 + 64'(k) * 64'd16);
      out_if.ready  = vt[k].ordy;
      @(negedge clk);
      chk1($sformatf("vec%0d_req0_ready", k), req0_if.ready, vt[k].r0);
      chk1($sformatf("vec%0d_req1_ready", k), req1_if.ready, vt[k].r1);
      tick();
    end
    idle_inputs();
    tick();
    @(negedge clk);
    chkn("vec_perf_stall", int'(perf_stall), 3);
    chk1("vec_err_oversize", err_oversize, 1'b1);
    chk1("vec_err_cdt_ovf", err_cdt_ovf, 1'b0);
    chkn("vec_cdt0", int'(dut.cdt0_q), 71);
    chkn("vec_cdt1", int'(dut.cdt1_q), 72);
    tick();
    stall_clr = 1'b1;
    tick();
    stall_clr = 1'b0;
    @(negedge clk);
    chkn("stall_clr", int'(perf_stall), 0);
    tick();

    // Contention alternates starting with req0
    do_reset();
    req0_if.valid = 1'b1;
    req1_if.valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      req0_if.pd = mk_pd(15'd0, 64'h4000 + 64'(k));
      req1_if.pd = mk_pd(15'd0, 64'h5000 + 64'(k));
      @(negedge clk);
      chk1($sformatf("rr%0d_req0", k), req0_if.ready, (k % 2) == 0);
      chk1($sformatf("rr%0d_req1", k), req1_if.ready, (k % 2) == 1);
      tick();
    end
    idle_inputs();
    @(negedge clk);
    chkn("rr_perf_stall", int'(perf_stall), 0);
    tick();

    // Credit exhaustion and refill by pops
    do_reset();
    req0_if.valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      req0_if.pd = mk_pd(15'd7, 64'h3000 + 64'(k));
      @(negedge clk);
      chk1($sformatf("cdt_grant%0d", k), req0_if.ready, 1'b1);
      tick();
    end
    req0_if.pd = mk_pd(15'd7, 64'h30FF);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1($sformatf("cdt_stall%0d", k), req0_if.ready, 1'b0);
      tick();
    end
    @(negedge clk);
    chkn("cdt0_empty", int'(dut.cdt0_q), 0);
    tick();
    for (int p = 0; p < 8; p++) begin
      cdt0_pop = 1'b1;
      @(negedge clk);
      chk1($sformatf("cdt_pop%0d_ready", p), req0_if.ready, 1'b0);
      tick();
    end
    cdt0_pop = 1'b0;
    @(negedge clk);
    chk1("cdt_refill_grant", req0_if.ready, 1'b1);
    chkn("cdt_perf_stall", int'(perf_stall), 12);
    tick();
    idle_inputs();
    tick();

    // Backpressure on the outbound channel
    do_reset();
    out_if.ready  = 1'b0;
    req0_if.valid = 1'b1;
    req0_if.pd    = mk_pd(15'd0, 64'hB0A0);
    @(negedge clk);
    chk1("bp_first_grant", req0_if.ready, 1'b1);
    tick();
    req0_if.pd = mk_pd(15'd0, 64'hB0B0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk1($sformatf("bp%0d_ready", k), req0_if.ready, 1'b0);
      chk1($sformatf("bp%0d_out_valid", k), out_if.valid, 1'b1);
      chk_pd($sformatf("bp%0d_out_pd", k), out_if.pd, mk_pd(15'd0, 64'hB0A0));
      tick();
    end
    out_if.ready = 1'b1;
    @(negedge clk);
    chk1("bp_release_grant", req0_if.ready, 1'b1);
    chkn("bp_perf_stall", int'(perf_stall), 5);
    tick();
    out_if.ready  = 1'b0;
    req0_if.valid = 1'b0;
    tick();
    do_reset();

    // Same-cycle grant and pop on req1
    req1_if.valid = 1'b1;
    req1_if.pd    = mk_pd(15'd69, 64'hC000);
    @(negedge clk);
    chk1("gp_first_grant", req1_if.ready, 1'b1);
    tick();
    req1_if.pd = mk_pd(15'd1, 64'hC100);
    cdt1_pop   = 1'b1;
    @(negedge clk);
    chk1("gp_second_grant", req1_if.ready, 1'b1);
    tick();
    req1_if.valid = 1'b0;
    cdt1_pop      = 1'b0;
    @(negedge clk);
    chkn("gp_cdt1", int'(dut.cdt1_q), 9);
    chkn("gp_cdt0", int'(dut.cdt0_q), 80);
    tick();

    // Error flags
    do_reset();
    cdt0_pop = 1'b1;
    tick();
    cdt0_pop = 1'b0;
    @(negedge clk);
    chkn("ovf_cdt0", int'(dut.cdt0_q), 80);
    chk1("ovf_flag", err_cdt_ovf, 1'b1);
    chk1("ovf_no_oversize", err_oversize, 1'b0);
    tick();
    req1_if.valid = 1'b1;
    req1_if.pd    = mk_pd(15'd100, 64'hD000);
    req0_if.valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req0_if.pd = mk_pd(15'd0, 64'hE000 + 64'(k));
      @(negedge clk);
      chk1($sformatf("os%0d_req0", k), req0_if.ready, 1'b1);
      chk1($sformatf("os%0d_req1", k), req1_if.ready, 1'b0);
      tick();
    end
    idle_inputs();
    repeat (3) tick();
    @(negedge clk);
    chk1("os_flag_sticky", err_oversize, 1'b1);
    chk1("ovf_flag_sticky", err_cdt_ovf, 1'b1);
    tick();
    chkn("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
